game_ctrl: RTL

Frame-rate game controller that produces the player-facing control interface consumed by the ball/character movers. Each frame it decodes up to four raw USB HID keycodes into an 8-bit action bitmap. It runs the game-state FSM that drives `current_state_out`, and it generates the `die` respawn pulse. It also tracks lives and post-respawn invulnerability. It sits between the USB keyboard interface and every movement/sprite block.

---
 rtl/game_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// Frame-rate game controller: HID keycode decode, game-state FSM, lives and respawn invulnerability.
// Optional macro GAME_CTRL_INFINITE_LIVES_EN: hits never cost a life.
module game_ctrl #(
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned RESPAWN_FRAMES = 60
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic [7:0] keycode2,
    input  logic [7:0] keycode3,
    input  logic       hazard_hit,
    output logic [7:0] keycode,
    output logic [1:0] current_state_out,
    output logic       die,
    output logic [2:0] lives,
    output logic       invuln
);

    typedef enum logic [1:0] {
        StMenu     = 2'd0,
        StPlaying  = 2'd1,
        StPaused   = 2'd2,
        StGameover = 2'd3
    } state_t;

    localparam logic [7:0] KeyA     = 8'h04;
    localparam logic [7:0] KeyW     = 8'h1A;
    localparam logic [7:0] KeyD     = 8'h07;
    localparam logic [7:0] KeyS     = 8'h16;
    localparam logic [7:0] KeyEnter = 8'h28;
    localparam logic [7:0] KeyP     = 8'h13;
    localparam logic [7:0] KeySpace = 8'h2C;
    localparam logic [7:0] KeyEsc   = 8'h29;

    // Bits that still reach the movers outside PLAYING: Enter, P, Esc.
    localparam logic [7:0] MenuMask = 8'h0D;

    localparam logic [7:0] RespawnLoad = 8'(RESPAWN_FRAMES);
    localparam logic [2:0] LivesLoad   = 3'(LIVES_INIT);

    state_t     state_q;
    logic [7:0] raw;
    logic [7:0] raw_q;
    logic [7:0] cnt_q;
    logic       ev_enter;
    logic       ev_pause;
    logic       ev_esc;
    logic       hit_ok;

    function automatic logic any_slot(input logic [7:0] code, input logic [7:0] k0,
                                      input logic [7:0] k1, input logic [7:0] k2,
                                      input logic [7:0] k3);
        return (k0 == code) || (k1 == code) || (k2 == code) || (k3 == code);
    endfunction

    always_comb begin
        raw    = 8'h00;
        raw[7] = any_slot(KeyA,     keycode0, keycode1, keycode2, keycode3);
        raw[6] = any_slot(KeyW,     keycode0, keycode1, keycode2, keycode3);
        raw[5] = any_slot(KeyD,     keycode0, keycode1, keycode2, keycode3);
        raw[4] = any_slot(KeyS,     keycode0, keycode1, keycode2, keycode3);
        raw[3] = any_slot(KeyEnter, keycode0, keycode1, keycode2, keycode3);
        raw[2] = any_slot(KeyP,     keycode0, keycode1, keycode2, keycode3);
        raw[1] = any_slot(KeySpace, keycode0, keycode1, keycode2, keycode3);
        raw[0] = any_slot(KeyEsc,   keycode0, keycode1, keycode2, keycode3);
    end

    assign ev_enter = raw[3] & ~raw_q[3];
    assign ev_pause = raw[2] & ~raw_q[2];
    assign ev_esc   = raw[0] & ~raw_q[0];
    assign hit_ok   = hazard_hit && (cnt_q == 8'd0);

    assign current_state_out = state_q;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StMenu;
            raw_q   <= 8'h00;
            cnt_q   <= 8'h00;
            keycode <= 8'h00;
            die     <= 1'b0;
            lives   <= 3'd0;
            invuln  <= 1'b0;
        end else begin
            raw_q   <= raw;
            keycode <= (state_q == StPlaying) ? raw : (raw & MenuMask);
            die     <= 1'b0;
            unique case (state_q)
                StMenu: begin
                    if (ev_enter) begin
                        state_q <= StPlaying;
                        lives   <= LivesLoad;
                        cnt_q   <= 8'd0;
                        invuln  <= 1'b0;
                        die     <= 1'b1;
                    end
                end
                StPlaying: begin
                    if (hit_ok) begin
                        die <= 1'b1;
`ifdef GAME_CTRL_INFINITE_LIVES_EN
                        if (lives == 3'd0) begin
                            state_q <= StGameover;
                            cnt_q   <= 8'd0;
                            invuln  <= 1'b0;
                        end else begin
                            cnt_q  <= RespawnLoad;
                            invuln <= (RespawnLoad != 8'd0);
                        end
`else
                        if (lives <= 3'd1) begin
                            lives   <= 3'd0;
                            state_q <= StGameover;
                            cnt_q   <= 8'd0;
                            invuln  <= 1'b0;
                        end else begin
                            lives  <= lives - 3'd1;
                            cnt_q  <= RespawnLoad;
                            invuln <= (RespawnLoad != 8'd0);
                        end
`endif
                    end else begin
                        if (cnt_q != 8'd0) begin
                            cnt_q  <= cnt_q - 8'd1;
                            invuln <= (cnt_q > 8'd1);
                        end
                        // Esc overrides P when both arrive on the same frame.
                        if (ev_esc) begin
                            state_q <= StMenu;
                            cnt_q   <= 8'd0;
                            invuln  <= 1'b0;
                        end else if (ev_pause) begin
                            state_q <= StPaused;
                        end
                    end
                end
                StPaused: begin
                    if (ev_esc) begin
                        state_q <= StMenu;
                        cnt_q   <= 8'd0;
                        invuln  <= 1'b0;
                    end else if (ev_pause) begin
                        state_q <= StPlaying;
                    end
                end
                StGameover: begin
                    if (ev_enter || ev_esc) begin
                        state_q <= StMenu;
                        cnt_q   <= 8'd0;
                        invuln  <= 1'b0;
                    end
                end
                default: state_q <= StMenu;
            endcase
        end
    end

endmodule
